// File: rtl/ikaopll_pg_pkg.sv
// Shared constants and helpers for the OPLL phase generator.
// Holds slot/width parameters, the MUL factor table and the vibrato magnitude select.
package ikaopll_pg_pkg;

    localparam int SLOTS   = 18;
    localparam int PHASE_W = 19;
    localparam int OUT_W   = 10;

    // Frequency multiple per MUL code, in half-units (1 = x0.5).
    localparam logic [4:0] MUL_FACTOR [16] = '{
        5'd1,  5'd2,  5'd4,  5'd6,
        5'd8,  5'd10, 5'd12, 5'd14,
        5'd16, 5'd18, 5'd20, 5'd20,
        5'd24, 5'd24, 5'd30, 5'd30
    };

    // Vibrato depth taken from the FNUM MSBs for the current LFO step.
    function automatic logic [2:0] pm_mag(
        input logic [8:0] fnum,
        input logic [1:0] sel
    );
        logic [2:0] mag;
        mag = 3'd0;
        unique case (sel)
            2'd0:    mag = 3'd0;
            2'd1:    mag = {1'b0, fnum[8:7]};
            2'd2:    mag = fnum[8:6];
            default: mag = {1'b0, fnum[8:7]};
        endcase
        return mag;
    endfunction

endpackage

// File: rtl/ikaopll_pg_incr.sv
// Phase increment pipeline: vibrato + block shift, then MUL scaling.
// Ports: clk_i, rst_i (sync), en_i, fnum/block/mul/pm/pmval, prst_i/tag_i in; inc_o, prst_o, tag_o out (latency 2).
module ikaopll_pg_incr
    import ikaopll_pg_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [8:0]         fnum_i,
    input  logic [2:0]         block_i,
    input  logic [3:0]         mul_i,
    input  logic               pm_i,
    input  logic [2:0]         pmval_i,
    input  logic               prst_i,
    input  logic               tag_i,
    output logic [PHASE_W-1:0] inc_o,
    output logic               prst_o,
    output logic               tag_o
);

    logic [2:0]  pm_delta;
    logic [9:0]  fext;
    logic [16:0] sh_full;
    logic [15:0] shifted_d, shifted_q;
    logic [3:0]  mul_q;
    logic        prst1_q, tag1_q;

    logic [19:0]        prod;
    logic [PHASE_W-1:0] inc_d, inc_q;
    logic               prst2_q, tag2_q;

    always_comb begin
        pm_delta  = pm_i ? pm_mag(fnum_i, pmval_i[1:0]) : 3'd0;
        // Bit 2 of the LFO step selects the downward half of the vibrato swing.
        fext      = pmval_i[2] ? ({fnum_i, 1'b0} - {7'd0, pm_delta})
                               : ({fnum_i, 1'b0} + {7'd0, pm_delta});
        sh_full   = {7'd0, fext} << block_i;
        shifted_d = 16'(sh_full >> 1);
    end

    always_comb begin
        prod  = {4'd0, shifted_q} * {15'd0, MUL_FACTOR[mul_q]};
        inc_d = PHASE_W'(prod >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (rst_i) begin
                shifted_q <= '0;
                mul_q     <= '0;
                prst1_q   <= 1'b0;
                tag1_q    <= 1'b0;
                inc_q     <= '0;
                prst2_q   <= 1'b0;
                tag2_q    <= 1'b0;
            end else begin
                shifted_q <= shifted_d;
                mul_q     <= mul_i;
                prst1_q   <= prst_i;
                tag1_q    <= tag_i;
                inc_q     <= inc_d;
                prst2_q   <= prst1_q;
                tag2_q    <= tag1_q;
            end
        end
    end

    assign inc_o  = inc_q;
    assign prst_o = prst2_q;
    assign tag_o  = tag2_q;

endmodule

// File: rtl/ikaopll_phase_gen.sv
// Time-multiplexed 18-slot phase generator with circulating 19-bit accumulators.
// Ports: i_EMUCLK, i_IC, i_phi1_NCEN_n, i_CYCLE_00, slot params, i_PG_PHASE_RST in; o_PHASE, o_SLOT0_VALID out.
module ikaopll_phase_gen
    import ikaopll_pg_pkg::*;
(
    input  logic             i_EMUCLK,
    input  logic             i_IC,
    input  logic             i_phi1_NCEN_n,
    input  logic             i_CYCLE_00,
    input  logic [8:0]       i_FNUM,
    input  logic [2:0]       i_BLOCK,
    input  logic [3:0]       i_MUL,
    input  logic             i_PM,
    input  logic [2:0]       i_PMVAL,
    input  logic             i_PG_PHASE_RST,
    output logic [OUT_W-1:0] o_PHASE,
    output logic             o_SLOT0_VALID
);

    logic               en;
    logic [PHASE_W-1:0] inc;
    logic               prst, tag;

    logic [PHASE_W-1:0] store_q [SLOTS];
    logic [PHASE_W-1:0] phase_d;
    logic [OUT_W-1:0]   out_q;
    logic               valid_q;

    assign en = ~i_phi1_NCEN_n;

    ikaopll_pg_incr u_incr (
        .clk_i   (i_EMUCLK),
        .rst_i   (i_IC),
        .en_i    (en),
        .fnum_i  (i_FNUM),
        .block_i (i_BLOCK),
        .mul_i   (i_MUL),
        .pm_i    (i_PM),
        .pmval_i (i_PMVAL),
        .prst_i  (i_PG_PHASE_RST),
        .tag_i   (i_CYCLE_00),
        .inc_o   (inc),
        .prst_o  (prst),
        .tag_o   (tag)
    );

    // Tail of the ring holds this slot's phase from the previous revolution.
    always_comb begin
        phase_d = store_q[SLOTS-1] + inc;
        if (i_IC || prst) begin
            phase_d = '0;
        end
    end

    // Ring has no reset of its own: a held clear sweeps zeros through it.
    always_ff @(posedge i_EMUCLK) begin
        if (en) begin
            store_q[0] <= phase_d;
            for (int i = 1; i < SLOTS; i++) begin
                store_q[i] <= store_q[i-1];
            end
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (en) begin
            if (i_IC) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                out_q   <= phase_d[PHASE_W-1 -: OUT_W];
                valid_q <= tag;
            end
        end
    end

    assign o_PHASE       = out_q;
    assign o_SLOT0_VALID = valid_q;

endmodule
